text_cell_fetch: RTL and testbench



---
 rtl/text_cell_fetch.sv | 116 +++++++++++
 tb/tb_text_cell_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/text_cell_fetch.sv
// Text-mode pixel fetch: raster coordinate -> text RAM word -> font ROM row -> aligned pixel.
// Five register stages: addr, RAM wait, font addr, ROM wait, output.
module text_cell_fetch #(
    parameter int COLS         = 80,
    parameter int ROWS         = 25,
    parameter int FONT_H       = 16,
    parameter int CURSOR_START = 14,
    parameter int BLINK_FRAMES = 16,
    parameter int BIT_WIDTH    = 10,
    parameter int BIT_HEIGHT   = 10
) (
    input  logic                            clk_pixel,
    input  logic                            reset,
    input  logic [BIT_WIDTH-1:0]            cx,
    input  logic [BIT_HEIGHT-1:0]           cy,
    input  logic                            de,
    input  logic                            frame_start,
    input  logic                            cursor_enable,
    input  logic [6:0]                      cursor_col,
    input  logic [4:0]                      cursor_row,
    output logic [$clog2(COLS*ROWS)-1:0]    text_addr,
    input  logic [15:0]                     text_data,
    output logic [8+$clog2(FONT_H)-1:0]     font_addr,
    input  logic [7:0]                      font_data,
    output logic [7:0]                      attribute,
    output logic                            glyph_bit,
    output logic                            cursor_hit,
    output logic                            blink_phase,
    output logic                            de_out
);
    localparam int AW  = $clog2(COLS*ROWS);
    localparam int SW  = $clog2(FONT_H);
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef struct packed {
        logic [SW-1:0] scan;
        logic [2:0]    pix;
        logic          cur;
    } sb_t;

    logic                      in_range;
    logic [BIT_WIDTH-4:0]      col;
    logic [BIT_HEIGHT-SW-1:0]  row;
    logic [AW-1:0]             text_addr_d;
    sb_t                       sb_d;
    logic                      glyph_d, cur_d;

    logic [4:0]                vld_pipe_q;
    sb_t [3:0]                 sb_q;
    logic [AW-1:0]             text_addr_q;
    logic [8+SW-1:0]           font_addr_q;
    logic [7:0]                attr3_q, attr4_q, attr_q;
    logic                      glyph_q, cur_q, blink_q;
    logic [FCW-1:0]            frame_count_q;

    always_comb begin
        col         = cx[BIT_WIDTH-1:3];
        row         = cy[BIT_HEIGHT-1:SW];
        in_range    = de && (32'(cx) < 32'(COLS*8)) && (32'(cy) < 32'(ROWS*FONT_H));
        text_addr_d = in_range ? AW'(32'(row) * 32'(COLS) + 32'(col)) : '0;
        sb_d.scan   = cy[SW-1:0];
        sb_d.pix    = cx[2:0];
        // cursor enable is folded in here so it is sampled with the coordinate
        sb_d.cur    = cursor_enable && (32'(col) == 32'(cursor_col))
                                    && (32'(row) == 32'(cursor_row));
    end

    always_comb begin
        glyph_d = font_data[3'd7 - sb_q[3].pix] & vld_pipe_q[3];
        cur_d   = vld_pipe_q[3] & sb_q[3].cur & blink_q
                & (32'(sb_q[3].scan) >= 32'(CURSOR_START));
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            vld_pipe_q    <= '0;
            sb_q          <= '0;
            text_addr_q   <= '0;
            font_addr_q   <= '0;
            attr3_q       <= '0;
            attr4_q       <= '0;
            attr_q        <= '0;
            glyph_q       <= 1'b0;
            cur_q         <= 1'b0;
            blink_q       <= 1'b1;
            frame_count_q <= '0;
        end else begin
            vld_pipe_q  <= {vld_pipe_q[3:0], in_range};
            sb_q        <= {sb_q[2:0], sb_d};
            text_addr_q <= text_addr_d;
            font_addr_q <= {text_data[7:0], sb_q[1].scan};
            attr3_q     <= text_data[15:8];
            attr4_q     <= attr3_q;
            attr_q      <= attr4_q & {8{vld_pipe_q[3]}};
            glyph_q     <= glyph_d;
            cur_q       <= cur_d;
            if (frame_start) begin
                if (frame_count_q == FCW'(BLINK_FRAMES-1)) begin
                    frame_count_q <= '0;
                    blink_q       <= ~blink_q;
                end else begin
                    frame_count_q <= frame_count_q + 1'b1;
                end
            end
        end
    end

    assign text_addr   = text_addr_q;
    assign font_addr   = font_addr_q;
    assign attribute   = attr_q;
    assign glyph_bit   = glyph_q;
    assign cursor_hit  = cur_q;
    assign blink_phase = blink_q;
    assign de_out      = vld_pipe_q[4];

endmodule

// File: tb/tb_text_cell_fetch.sv
// Directed bench for text_cell_fetch with behavioural text RAM / font ROM (1-cycle read).
module tb_text_cell_fetch;
    logic        clk_pixel = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  cx = '0;
    logic [9:0]  cy = '0;
    logic        de = 1'b0;
    logic        frame_start = 1'b0;
    logic        cursor_enable = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [4:0]  cursor_row = '0;
    logic [10:0] text_addr;
    logic [15:0] text_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [7:0]  attribute;
    logic        glyph_bit, cursor_hit, blink_phase, de_out;

    text_cell_fetch dut (
        .clk_pixel(clk_pixel), .reset(reset), .cx(cx), .cy(cy), .de(de),
        .frame_start(frame_start), .cursor_enable(cursor_enable),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .text_addr(text_addr), .text_data(text_data),
        .font_addr(font_addr), .font_data(font_data),
        .attribute(attribute), .glyph_bit(glyph_bit), .cursor_hit(cursor_hit),
        .blink_phase(blink_phase), .de_out(de_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    logic [15:0] ram [0:2047];
    logic [7:0]  rom [0:4095];
    always @(posedge clk_pixel) begin
        text_data <= ram[text_addr];
        font_data <= rom[font_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       chk;
        logic [7:0] attr;
        logic       g;
        logic       cur;
        logic       d;
    } exp_t;

    exp_t dly [0:4];

    function automatic exp_t mk(input logic [7:0] a, input logic g, input logic c, input logic d);
        exp_t e;
        e.chk = 1'b1; e.attr = a; e.g = g; e.cur = c; e.d = d;
        return e;
    endfunction

    // Called on a negedge: check the pixel driven five negedges ago, then drive a new one.
    task automatic px(input logic d, input int x, input int y, input logic ce, input exp_t e);
        if (dly[4].chk) begin
            chk("attr", attribute, dly[4].attr);
            chk("glyph", glyph_bit, dly[4].g);
            chk("cursor", cursor_hit, dly[4].cur);
            chk("de_out", de_out, dly[4].d);
        end
        for (int i = 4; i > 0; i--) dly[i] = dly[i-1];
        dly[0] = e;
        de = d; cx = 10'(x); cy = 10'(y); cursor_enable = ce;
        @(negedge clk_pixel);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 0, 0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        @(negedge clk_pixel);
        frame_start = 1'b0;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_ta"}, text_addr, 0);
        chk({tag, "_fa"}, font_addr, 0);
        chk({tag, "_attr"}, attribute, 0);
        chk({tag, "_glyph"}, glyph_bit, 0);
        chk({tag, "_cur"}, cursor_hit, 0);
        chk({tag, "_de"}, de_out, 0);
        chk({tag, "_blink"}, blink_phase, 1);
    endtask

    initial begin
        logic [7:0] brow;
        exp_t blank;
        blank = mk(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2048; i++) ram[i] = '0;
        for (int i = 0; i < 4096; i++) rom[i] = '0;
        for (int i = 0; i < 5; i++) dly[i] = '0;
        ram[0]    = 16'h1F41;  rom[12'h410] = 8'h18;   // 'A' row 0
        ram[161]  = 16'h2E42;  rom[12'h421] = 8'hA5;   // 'B' row 1
        ram[79]   = 16'h7041;
        ram[1920] = 16'h0F43;  rom[12'h43F] = 8'h80;   // 'C' row 15
        ram[163]  = 16'h0700;

        repeat (3) @(negedge clk_pixel);
        rst_chk("reset");
        reset = 1'b0;

        // single pixel (0,0): address and font address timing
        de = 1'b1; cx = 10'd0; cy = 10'd0;
        @(negedge clk_pixel); chk("ta_a", text_addr, 0); de = 1'b0;
        @(negedge clk_pixel); @(negedge clk_pixel); chk("fa_a", font_addr, 12'h410);
        @(negedge clk_pixel); @(negedge clk_pixel);
        chk("attr_a", attribute, 8'h1F); chk("de_a", de_out, 1); chk("g_a", glyph_bit, 0);

        // single pixel (8,33)
        de = 1'b1; cx = 10'd8; cy = 10'd33;
        @(negedge clk_pixel); chk("ta_b", text_addr, 161); de = 1'b0;
        @(negedge clk_pixel); @(negedge clk_pixel); chk("fa_b", font_addr, 12'h421);
        @(negedge clk_pixel); @(negedge clk_pixel);
        chk("attr_b", attribute, 8'h2E); chk("g_b", glyph_bit, 1);

        // streaming: row 0 of 'A', full 'B' row, boundaries, then out-of-range blanks
        for (int i = 0; i < 5; i++) px(1'b1, i, 0, 1'b0, mk(8'h1F, (i >= 3), 1'b0, 1'b1));
        brow = 8'hA5;
        for (int i = 0; i < 8; i++) px(1'b1, 8 + i, 33, 1'b0, mk(8'h2E, brow[7-i], 1'b0, 1'b1));
        px(1'b1, 640, 0, 1'b0, blank);
        px(1'b0, 8, 33, 1'b0, blank);
        px(1'b1, 0, 400, 1'b0, blank);
        px(1'b1, 636, 0, 1'b0, mk(8'h70, 1'b1, 1'b0, 1'b1));
        px(1'b1, 0, 399, 1'b0, mk(8'h0F, 1'b1, 1'b0, 1'b1));
        px(1'b1, 1023, 399, 1'b0, blank);
        flush(5);

        // cursor at column 3, row 2
        cursor_col = 7'd3; cursor_row = 5'd2;
        px(1'b1, 24, 46, 1'b1, mk(8'h07, 1'b0, 1'b1, 1'b1));
        px(1'b1, 31, 47, 1'b1, mk(8'h07, 1'b0, 1'b1, 1'b1));
        px(1'b1, 27, 32, 1'b1, mk(8'h07, 1'b0, 1'b0, 1'b1));
        px(1'b1, 24, 45, 1'b1, mk(8'h07, 1'b0, 1'b0, 1'b1));
        px(1'b1, 32, 46, 1'b1, mk(8'h00, 1'b0, 1'b0, 1'b1));
        px(1'b1, 23, 46, 1'b1, mk(8'h00, 1'b0, 1'b0, 1'b1));
        px(1'b1, 24, 47, 1'b0, mk(8'h07, 1'b0, 1'b0, 1'b1));
        flush(5);

        // blink: toggles on the 16th and 32nd frame_start
        for (int i = 0; i < 15; i++) pulse();
        chk("blink_15", blink_phase, 1);
        pulse();
        chk("blink_16", blink_phase, 0);
        px(1'b1, 24, 46, 1'b1, mk(8'h07, 1'b0, 1'b0, 1'b1));
        flush(5);
        for (int i = 0; i < 15; i++) pulse();
        chk("blink_31", blink_phase, 0);
        pulse();
        chk("blink_32", blink_phase, 1);

        // mid-line reset with pixels in flight and a non-zero frame count
        for (int i = 0; i < 20; i++) pulse();
        chk("blink_pre_rst", blink_phase, 0);
        for (int i = 0; i < 4; i++) px(1'b1, 24 + i, 46, 1'b1, '0);
        reset = 1'b1;
        @(negedge clk_pixel);
        rst_chk("midrst");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) dly[i] = blank;
        flush(6);
        for (int i = 0; i < 15; i++) pulse();
        chk("fc_rst_15", blink_phase, 1);
        pulse();
        chk("fc_rst_16", blink_phase, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
